// File: rtl/block_scan_scheduler.sv
// Raster-order block sequencer for the 8x8 (u,v) index counter: one 64-index scan per block.
// Define SCHED_STALL_CNT_EN to add the 16-bit saturating o_stall_cycles output.
module block_scan_scheduler #(
  parameter int BLKS_X = 80,
  parameter int BLKS_Y = 60,
  parameter int XW     = 7,
  parameter int YW     = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_src_ready,
  input  logic          i_dst_ready,
  input  logic          i_cnt_done,
  output logic          o_cnt_go,
  output logic          o_cnt_restart,
  output logic          o_src_release,
  output logic [XW-1:0] o_blk_x,
  output logic [YW-1:0] o_blk_y,
  output logic          o_busy,
`ifdef SCHED_STALL_CNT_EN
  output logic [15:0]   o_stall_cycles,
`endif
  output logic          o_frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SCAN    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(BLKS_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(BLKS_Y - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [XW-1:0] r_blk_x;
  logic [XW-1:0] w_blk_x_next;
  logic [YW-1:0] r_blk_y;
  logic [YW-1:0] w_blk_y_next;
  logic          w_start_accept;
  logic          w_last_blk;
  logic          w_cnt_go;

  assign w_start_accept = (r_state == ST_IDLE) && i_start;
  assign w_last_blk     = (r_blk_x == X_LAST) && (r_blk_y == Y_LAST);
  // The only combinational output path: the scan freezes the same cycle dst_ready drops.
  assign w_cnt_go       = (r_state == ST_SCAN) && i_dst_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_blk_x <= '0;
      r_blk_y <= '0;
    end else begin
      r_state <= w_state_next;
      r_blk_x <= w_blk_x_next;
      r_blk_y <= w_blk_y_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_blk_x_next = r_blk_x;
    w_blk_y_next = r_blk_y;
    // Abort outranks everything except a start accepted in IDLE.
    if ((r_state != ST_IDLE) && i_abort) begin
      w_state_next = ST_IDLE;
      w_blk_x_next = '0;
      w_blk_y_next = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_accept) begin
            w_state_next = ST_RESTART;
            w_blk_x_next = '0;
            w_blk_y_next = '0;
          end
        end
        ST_RESTART: begin
          w_state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_src_ready && i_dst_ready) begin
            w_state_next = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_cnt_go && i_cnt_done) begin
            w_state_next = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_last_blk) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RESTART;
            if (r_blk_x == X_LAST) begin
              w_blk_x_next = '0;
              w_blk_y_next = r_blk_y + YW'(1);
            end else begin
              w_blk_x_next = r_blk_x + XW'(1);
            end
          end
        end
        ST_DONE: begin
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign o_cnt_go      = w_cnt_go;
  assign o_cnt_restart = (r_state == ST_RESTART);
  assign o_src_release = (r_state == ST_RELEASE);
  assign o_frame_done  = (r_state == ST_DONE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_blk_x       = r_blk_x;
  assign o_blk_y       = r_blk_y;

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cycles;
  logic        w_stall_event;

  assign w_stall_event = ((r_state == ST_WAIT) && !(i_src_ready && i_dst_ready)) ||
                         ((r_state == ST_SCAN) && !i_dst_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_start_accept) begin
      r_stall_cycles <= '0;
    end else if (w_stall_event && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_block_scan_scheduler.sv
// Bench for block_scan_scheduler on a 2x2-block frame: per-cycle model compare plus literal timing checks.
// Follows SCHED_STALL_CNT_EN to also check the stall counter.
module tb_block_scan_scheduler;

  localparam int BX = 2;
  localparam int BY = 2;
  localparam int XW = 2;
  localparam int YW = 2;

  localparam int P_IDLE    = 0;
  localparam int P_RESTART = 1;
  localparam int P_WAIT    = 2;
  localparam int P_SCAN    = 3;
  localparam int P_RELEASE = 4;
  localparam int P_DONE    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          src_rdy = 1'b0;
  logic          dst_rdy = 1'b0;
  logic          spur = 1'b0;
  logic          cnt_done;
  logic          cnt_go;
  logic          cnt_restart;
  logic          src_release;
  logic [XW-1:0] blk_x;
  logic [YW-1:0] blk_y;
  logic          busy;
  logic          frame_done;
`ifdef SCHED_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  // Stand-in for the double counter: index 0..63, done at 63.
  int ctr_k = 0;
  assign cnt_done = (ctr_k == 63) || spur;

  always #5 clk = ~clk;

  block_scan_scheduler #(.BLKS_X(BX), .BLKS_Y(BY), .XW(XW), .YW(YW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_src_ready   (src_rdy),
    .i_dst_ready   (dst_rdy),
    .i_cnt_done    (cnt_done),
    .o_cnt_go      (cnt_go),
    .o_cnt_restart (cnt_restart),
    .o_src_release (src_release),
    .o_blk_x       (blk_x),
    .o_blk_y       (blk_y),
    .o_busy        (busy),
`ifdef SCHED_STALL_CNT_EN
    .o_stall_cycles(stall_cycles),
`endif
    .o_frame_done  (frame_done)
  );

  // Model: activity phase, linear block index in raster order, stall tally.
  int m_ph    = P_IDLE;
  int m_blk   = 0;
  int m_stall = 0;

  int n_cmp = 0;
  int n_bad = 0;

  int n_ticks = 0;
  int t_start = 0;
  int obs_restarts, obs_gos, obs_blk_gos, last_blk_gos, obs_fds;
  bit last_go, last_rel, last_fd;
  int rel_x[$];
  int rel_y[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: compare at negedge, model/env update just after posedge.
  task automatic tick();
    bit c_start, c_abort, c_src, c_dst, c_done, c_go, c_rs, c_rel, c_fd;
    @(negedge clk);
    chk("busy",        int'(busy),        int'(m_ph != P_IDLE));
    chk("cnt_restart", int'(cnt_restart), int'(m_ph == P_RESTART));
    chk("cnt_go",      int'(cnt_go),      int'((m_ph == P_SCAN) && dst_rdy));
    chk("src_release", int'(src_release), int'(m_ph == P_RELEASE));
    chk("frame_done",  int'(frame_done),  int'(m_ph == P_DONE));
    chk("blk_x",       int'(blk_x),       m_blk % BX);
    chk("blk_y",       int'(blk_y),       m_blk / BX);
`ifdef SCHED_STALL_CNT_EN
    chk("stall_cycles", int'(stall_cycles), m_stall);
`endif
    c_start = start; c_abort = abort; c_src = src_rdy; c_dst = dst_rdy; c_done = cnt_done;
    c_go = cnt_go; c_rs = cnt_restart; c_rel = src_release; c_fd = frame_done;
    if (c_rs) obs_restarts++;
    if (c_go) begin obs_gos++; obs_blk_gos++; end
    if (c_fd) obs_fds++;
    if (c_rel) begin
      rel_x.push_back(int'(blk_x));
      rel_y.push_back(int'(blk_y));
      last_blk_gos = obs_blk_gos;
      obs_blk_gos = 0;
    end
    last_go = c_go; last_rel = c_rel; last_fd = c_fd;
    @(posedge clk);
    #1;
    n_ticks++;
    if (c_rs) ctr_k = 0;
    else if (c_go) ctr_k = (ctr_k + 1) % 64;
    if (rst_n) begin
      if (((m_ph == P_WAIT) && !(c_src && c_dst)) || ((m_ph == P_SCAN) && !c_dst))
        m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if ((m_ph != P_IDLE) && c_abort) begin
        m_ph = P_IDLE;
        m_blk = 0;
      end else begin
        case (m_ph)
          P_IDLE:    if (c_start) begin m_ph = P_RESTART; m_blk = 0; m_stall = 0; end
          P_RESTART: m_ph = P_WAIT;
          P_WAIT:    if (c_src && c_dst) m_ph = P_SCAN;
          P_SCAN:    if (c_dst && c_done) m_ph = P_RELEASE;
          P_RELEASE: if (m_blk == BX * BY - 1) m_ph = P_DONE;
                     else begin m_blk++; m_ph = P_RESTART; end
          default:   m_ph = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic start_frame();
    obs_restarts = 0; obs_gos = 0; obs_blk_gos = 0; last_blk_gos = 0; obs_fds = 0;
    rel_x.delete(); rel_y.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    t_start = n_ticks;
  endtask

  // Returns ticks since the start edge at which src_release was seen (-1 on timeout).
  task automatic wait_release(output int lat);
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (last_rel) begin lat = n_ticks - t_start; break; end
    end
  endtask

  task automatic wait_blk_gos(input int target, input string name);
    for (int i = 0; i < 300 && obs_blk_gos < target; i++) tick();
    chk(name, obs_blk_gos, target);
  endtask

  task automatic run_full_frame(input string tag);
    int ex[4];
    int ey[4];
    int fd_at;
    ex = '{0, 1, 0, 1};
    ey = '{0, 0, 1, 1};
    src_rdy = 1'b1; dst_rdy = 1'b1;
    start_frame();
    fd_at = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (last_fd) begin fd_at = n_ticks - t_start - 1; break; end
    end
    chk({tag, "_done_latency"}, fd_at, 268);
    chk({tag, "_restarts"}, obs_restarts, 4);
    chk({tag, "_go_total"}, obs_gos, 256);
    chk({tag, "_releases"}, rel_x.size(), 4);
    for (int i = 0; i < 4 && i < rel_x.size(); i++) begin
      chk({tag, "_rel_x"}, rel_x[i], ex[i]);
      chk({tag, "_rel_y"}, rel_y[i], ey[i]);
    end
    tick();
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int first_go;

    // Reset state
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_blk_x", int'(blk_x), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Unstalled 2x2 frame
    run_full_frame("t1");

    // src_ready low for 10 WAIT cycles
    src_rdy = 1'b0; dst_rdy = 1'b1;
    start_frame();
    first_go = -1; lat = -1;
    for (int i = 1; i <= 200; i++) begin
      src_rdy = (i >= 12);
      tick();
      if (last_go && first_go < 0) first_go = i;
      if (last_rel) begin lat = i; break; end
    end
    chk("t2_first_go", first_go, 13);
    chk("t2_block_len", lat, 77);
    chk("t2_block_gos", last_blk_gos, 64);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t2_abort_idle", int'(busy), 0);

    // dst_ready low for 5 SCAN cycles
    src_rdy = 1'b1; dst_rdy = 1'b1;
    start_frame();
    wait_blk_gos(20, "t3_reach20");
    dst_rdy = 1'b0;
    repeat (5) begin
      tick();
      chk("t3_go_frozen", int'(last_go), 0);
    end
    dst_rdy = 1'b1;
    wait_release(lat);
    chk("t3_block_len", lat, 72);
    chk("t3_block_gos", last_blk_gos, 64);
`ifdef SCHED_STALL_CNT_EN
    chk("t3_stall", int'(stall_cycles), 5);
`endif
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort during SCAN of block (1,0), then a clean frame
    start_frame();
    wait_release(lat);
    wait_blk_gos(10, "t4_reach10");
    chk("t4_in_blk1", int'(blk_x), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_x", int'(blk_x), 0);
    chk("t4_abort_y", int'(blk_y), 0);
    tick();
    chk("t4_no_frame_done", obs_fds, 0);
    run_full_frame("t4");

    // start ignored during SCAN, then async reset mid-cycle
    start_frame();
    wait_blk_gos(5, "t5_reach5");
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    chk("t5_scan_continues", obs_blk_gos, 9);
    chk("t5_still_busy", int'(busy), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_go", int'(cnt_go), 0);
    chk("t5_async_x", int'(blk_x), 0);
    m_ph = P_IDLE; m_blk = 0; m_stall = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Spurious cnt_done in RESTART/WAIT and while cnt_go is low
    src_rdy = 1'b0; dst_rdy = 1'b1; spur = 1'b1;
    start_frame();
    tick();
    repeat (3) tick();
    src_rdy = 1'b1;
    tick();
    spur = 1'b0;
    chk("t6_no_early_release", rel_x.size(), 0);
    wait_blk_gos(30, "t6_reach30");
    dst_rdy = 1'b0; spur = 1'b1;
    repeat (3) tick();
    dst_rdy = 1'b1; spur = 1'b0;
    wait_release(lat);
    chk("t6_block_len", lat, 73);
    chk("t6_block_gos", last_blk_gos, 64);
    chk("t6_restarts", obs_restarts, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
